// File: rtl/neurocam_req_sched.sv
// neurocam_req_sched: round-robin scheduler serialising search/write patterns into the NeuroCAM nibble protocol
module neurocam_req_sched #(
  parameter int NUM_REQ = 2,
  parameter int PAT_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [NUM_REQ*PAT_W-1:0] req_pattern,
  input  logic [2:0]               cfg_mode,
  output logic [7:0]               cam_ctrl,
  output logic [7:0]               cam_data,
  input  logic [7:0]               cam_result,
  input  logic [7:0]               cam_conf,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic                     rsp_op,
  output logic [4:0]               rsp_dist,
  output logic [1:0]               rsp_tag,
  output logic [7:0]               rsp_conf,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [7:0]               stat_search,
  output logic [7:0]               stat_timeout
);
  localparam int IW = NUM_REQ > 2 ? 2 : 1;
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, RESP} state_t;
  state_t st, st_n;
  logic [1:0] cnt, cnt_n, last, id, nib;
  logic [IW-1:0] j, win;
  logic [2:0] s, mode, mode_n;
  logic found, op, op_n, acc, done, hit, tmo;
  logic [PAT_W-1:0] pat, pat_n;
  logic [3:0] nd;
  logic [7:0] wcnt, ctrl_n, data_n;
  always_comb begin
    found = 1'b0;
    win = '0;
    s = '0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = 3'(last) + 3'(k);
      s = s >= 3'(NUM_REQ) ? s - 3'(NUM_REQ) : s;
      j = IW'(s);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  assign acc = rst_n && st == IDLE && found;
  assign req_ready = acc ? NUM_REQ'(1) << win : '0;
  always_comb begin
    hit = cam_result[7];
    tmo = wcnt == 8'(TIMEOUT);
    st_n = st;
    cnt_n = cnt;
    case (st)
      IDLE: if (found) begin st_n = LOAD; cnt_n = 2'd0; end
      LOAD: begin cnt_n = cnt + 2'd1; if (cnt == 2'd3) st_n = FIRE; end
      FIRE: begin cnt_n = cnt + 2'd1; if (!op) st_n = WAIT; else if (cnt == 2'd1) st_n = RESP; end
      WAIT: if (hit || tmo) st_n = RESP;
      RESP: if (rsp_ready) st_n = IDLE;
      default: st_n = IDLE;
    endcase
    op_n = acc ? req_op[win] : op;
    pat_n = acc ? req_pattern[{win, 4'b0} +: PAT_W] : pat;
    mode_n = acc ? cfg_mode : mode;
    nib = st_n == LOAD ? cnt_n : 2'd3;
    nd = pat_n[{nib, 2'b0} +: 4];
    ctrl_n = (st_n == LOAD || st_n == FIRE) ? {st_n == FIRE && !op_n, st_n == FIRE && op_n, 1'b0, mode_n, nib} : 8'h0;
    data_n = (st_n == LOAD || st_n == FIRE) ? (op_n ? {nd, 4'h0} : {4'h0, nd}) : 8'h0;
    done = st != RESP && st_n == RESP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      last <= 2'(NUM_REQ - 1);
      id <= '0;
      op <= 1'b0;
      pat <= '0;
      mode <= '0;
      wcnt <= '0;
      cam_ctrl <= '0;
      cam_data <= '0;
      rsp_valid <= 1'b0;
      busy <= 1'b0;
      rsp_id <= '0;
      rsp_op <= 1'b0;
      rsp_dist <= 5'd31;
      rsp_tag <= '0;
      rsp_conf <= '0;
      rsp_timeout <= 1'b0;
      stat_search <= '0;
      stat_timeout <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      op <= op_n;
      pat <= pat_n;
      mode <= mode_n;
      cam_ctrl <= ctrl_n;
      cam_data <= data_n;
      rsp_valid <= st_n == RESP;
      busy <= st_n != IDLE;
      wcnt <= st == WAIT ? wcnt + 8'd1 : 8'd0;
      if (acc) begin
        last <= 2'(win);
        id <= 2'(win);
      end
      if (done) begin
        rsp_id <= id;
        rsp_op <= op;
        rsp_dist <= op ? 5'd0 : hit ? cam_result[6:2] : 5'd31;
        rsp_tag <= !op && hit ? cam_result[1:0] : 2'd0;
        rsp_conf <= !op && hit ? cam_conf : 8'd0;
        rsp_timeout <= !op && !hit;
        stat_search <= stat_search + 8'(!op && stat_search != 8'hff);
        stat_timeout <= stat_timeout + 8'(!op && !hit && stat_timeout != 8'hff);
      end
    end
  end
endmodule

// File: tb/tb_neurocam_req_sched.sv
// tb_neurocam_req_sched: randomized and directed checks of neurocam_req_sched against a timeline-level reference model
module tb_neurocam_req_sched;
  localparam int N = 2;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] req_op = '0;
  logic [N*16-1:0] req_pattern = '0;
  logic [2:0] cfg_mode = '0;
  logic [7:0] cam_ctrl, cam_data;
  logic [7:0] cam_result = '0;
  logic [7:0] cam_conf = '0;
  logic rsp_valid, rsp_op, rsp_timeout, busy;
  logic rsp_ready = 1'b0;
  logic [1:0] rsp_id, rsp_tag;
  logic [4:0] rsp_dist;
  logic [7:0] rsp_conf, stat_search, stat_timeout;
  int tests = 0;
  int fails = 0;
  logic [N-1:0] rr = '0;
  int m_busy = 0, m_resp = 0, ph = 0, m_op = 0, m_id = 0, m_last = N - 1;
  logic [15:0] m_pat = '0;
  logic [2:0] m_mode = '0;
  int e_dist = 31, e_tag = 0, e_conf = 0, e_to = 0, e_id = 0, e_op = 0, s_srch = 0, s_to = 0;

  always #5 clk = ~clk;

  neurocam_req_sched #(.NUM_REQ(N), .PAT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pattern(req_pattern), .cfg_mode(cfg_mode), .cam_ctrl(cam_ctrl), .cam_data(cam_data),
    .cam_result(cam_result), .cam_conf(cam_conf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_dist(rsp_dist), .rsp_tag(rsp_tag), .rsp_conf(rsp_conf),
    .rsp_timeout(rsp_timeout), .busy(busy), .stat_search(stat_search), .stat_timeout(stat_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic complete(input int d, input int t, input int c, input int to);
    m_resp = 1;
    e_dist = d;
    e_tag = t;
    e_conf = c;
    e_to = to;
    e_id = m_id;
    e_op = m_op;
    if (m_op == 0 && s_srch < 255) s_srch++;
    if (to != 0 && s_to < 255) s_to++;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_last = N - 1;
      e_dist = 31; e_tag = 0; e_conf = 0; e_to = 0; e_id = 0; e_op = 0; s_srch = 0; s_to = 0;
    end else if (m_busy == 0) begin
      w = winner();
      if (w >= 0) begin
        m_busy = 1; ph = 1; m_op = int'(req_op[w]); m_pat = req_pattern[16*w +: 16];
        m_mode = cfg_mode; m_id = w; m_last = w;
      end
    end else if (m_resp != 0) begin
      if (rsp_ready) begin m_busy = 0; m_resp = 0; end
    end else if (m_op == 1 && ph == 6) complete(0, 0, 0, 0);
    else if (m_op == 0 && ph >= 6 && cam_result[7]) complete(int'(cam_result[6:2]), int'(cam_result[1:0]), int'(cam_conf), 0);
    else if (m_op == 0 && ph - 6 == TO) complete(31, 0, 0, 1);
    else ph++;
  endtask

  task automatic compare();
    int n;
    logic ld, fr;
    logic [3:0] nb;
    logic [7:0] ec, ed;
    ld = m_busy != 0 && m_resp == 0 && ph <= 4;
    fr = m_busy != 0 && m_resp == 0 && (ph == 5 || (m_op == 1 && ph == 6));
    n = ld ? ph - 1 : 3;
    nb = 4'((m_pat >> (4 * n)) & 16'hF);
    ec = (ld || fr) ? {fr && m_op == 0, fr && m_op == 1, 1'b0, m_mode, 2'(n)} : 8'h0;
    ed = !(ld || fr) ? 8'h0 : (m_op == 1) ? {nb, 4'h0} : {4'h0, nb};
    chk("busy", busy, m_busy != 0);
    chk("rsp_valid", rsp_valid, m_resp != 0);
    chk("cam_ctrl", cam_ctrl, ec);
    chk("cam_data", cam_data, ed);
    chk("rsp_id", rsp_id, e_id);
    chk("rsp_op", rsp_op, e_op);
    chk("rsp_dist", rsp_dist, e_dist);
    chk("rsp_tag", rsp_tag, e_tag);
    chk("rsp_conf", rsp_conf, e_conf);
    chk("rsp_timeout", rsp_timeout, e_to);
    chk("stat_search", stat_search, s_srch);
    chk("stat_timeout", stat_timeout, s_to);
  endtask

  task automatic step();
    int w;
    @(negedge clk);
    w = winner();
    rr = req_ready;
    chk("req_ready", rr, (rst_n && m_busy == 0 && w >= 0) ? (1 << w) : 0);
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic rand_run(input int cycles, input int den, input bit rst_ok, input bit srch_only);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rr[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[i] = 1'b1;
            req_op[i] = srch_only ? 1'b0 : 1'($urandom_range(1));
            req_pattern[16*i +: 16] = 16'($urandom);
          end
        end else if ($urandom_range(39) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = $urandom_range(3) != 0;
      cfg_mode = 3'($urandom);
      cam_result = {den != 0 && $urandom_range(den > 0 ? den - 1 : 0) == 0, 7'($urandom)};
      cam_conf = 8'($urandom);
      rst_n = !(rst_ok && $urandom_range(999) == 0);
      step();
    end
  endtask

  initial begin
    int cnt, g;
    logic [15:0] v;
    logic [7:0] seq;
    int dens[4];
    dens = '{1, 4, 12, 0};
    rst_n = 1'b0;
    step();
    step();
    chk("reset rsp_dist", rsp_dist, 31);
    chk("reset busy", busy, 0);
    chk("reset cam_ctrl", cam_ctrl, 0);
    rst_n = 1'b1;
    step();
    cfg_mode = 3'd5; req_valid = 2'b01; req_op = 2'b00; req_pattern = {16'h0, 16'h1234};
    step();
    chk("search accept", rr, 2'b01);
    req_valid = '0; cfg_mode = '0; v = 16'h1234;
    for (int n = 0; n < 4; n++) begin
      chk("search nibble", cam_data, {4'h0, v[4*n +: 4]});
      step();
    end
    chk("search fire", cam_ctrl, 8'h97);
    step();
    chk("search fire once", cam_ctrl[7], 0);
    step();
    step();
    cam_result = 8'h8E; cam_conf = 8'h18;
    step();
    cam_result = 8'h00; cam_conf = 8'h00;
    chk("search rsp_valid", rsp_valid, 1);
    chk("search dist", rsp_dist, 3);
    chk("search tag", rsp_tag, 2);
    chk("search conf", rsp_conf, 8'h18);
    chk("search id", rsp_id, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b10; req_op = 2'b10; req_pattern = {16'hBEEF, 16'h0};
    step();
    chk("write accept", rr, 2'b10);
    req_valid = '0; v = 16'hBEEF;
    for (int n = 0; n < 4; n++) begin
      chk("write nibble", cam_data, {v[4*n +: 4], 4'h0});
      step();
    end
    chk("write fire1", cam_ctrl[6], 1);
    step();
    chk("write fire2", cam_ctrl[6], 1);
    step();
    chk("write rsp_valid", rsp_valid, 1);
    chk("write rsp_op", rsp_op, 1);
    chk("write rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    step();
    req_valid = 2'b11; req_op = 2'b00; req_pattern = 32'h0F0F_A5A5; cam_result = 8'h80;
    g = 0; seq = '0;
    for (int c = 0; c < 200 && g < 4; c++) begin
      step();
      if (rr != 0) begin
        seq[2*g +: 2] = rr == 2'b10 ? 2'd1 : 2'd0;
        g++;
      end
    end
    chk("alt count", g, 4);
    chk("alt order", seq, 8'h44);
    req_valid = '0; cam_result = 8'h00;
    for (int c = 0; c < 40 && busy; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rsp_ready = 1'b0;
    step();
    req_valid = 2'b01;
    step();
    chk("timeout accept", rr, 2'b01);
    req_valid = '0; cnt = 1;
    while (!rsp_valid && cnt < 60) begin step(); cnt++; end
    chk("timeout latency", cnt, 22);
    chk("timeout flag", rsp_timeout, 1);
    chk("timeout dist", rsp_dist, 31);
    chk("timeout stat_timeout", stat_timeout, 1);
    chk("timeout stat_search", stat_search, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 2'b01;
    step();
    req_valid = '0; cam_result = 8'h8F;
    step();
    cam_result = 8'h00; cnt = 2;
    while (!rsp_valid && cnt < 60) begin step(); cnt++; end
    chk("pulse latency", cnt, 22);
    chk("pulse ignored", rsp_timeout, 1);
    chk("pulse stat_timeout", stat_timeout, 2);
    chk("pulse stat_search", stat_search, 2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 2'b10;
    step();
    chk("wait accept", rr, 2'b10);
    req_valid = '0;
    repeat (7) step();
    chk("in wait busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst cam_ctrl", cam_ctrl, 0);
    req_valid = 2'b11;
    step();
    chk("post reset grant", rr, 2'b01);
    rand_run(9000, 0, 1'b0, 1'b1);
    chk("sat stat_search", stat_search, 255);
    chk("sat stat_timeout", stat_timeout, 255);
    for (int e = 0; e < 24; e++) rand_run(300, dens[e % 4], 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neurocam_req_sched.md
# neurocam_req_sched

Request scheduler in front of the NeuroCAM core. It arbitrates search and write requests from NUM_REQ requesters and serialises each 16-bit pattern into the CAM's 4-cycle nibble protocol. It then fires the operation, waits for the CAM result with a timeout, and returns a tagged response to the requester. It sits between the host-side request ports and the CAM's ui_in/uio_in/uo_out/uio_out pins.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- PAT_W, 16: pattern width. Fixed at 4 nibbles.
- TIMEOUT, 15: maximum WAIT cycles for a search result, 1..255.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_op  in  NUM_REQ  per requester: 0 = search, 1 = write.
- req_pattern  in  NUM_REQ*16  flat; requester i uses bits [16i+15:16i].
- cfg_mode  in  3  match mode; sampled at accept.
- cam_ctrl  out  8  drives CAM ui_in: [7] search_en, [6] write_en, [5] 0, [4:2] mode, [1:0] nibble index.
- cam_data  out  8  drives CAM uio_in.
- cam_result  in  8  CAM uo_out: [7] match_valid, [6:2] distance, [1:0] addr tag.
- cam_conf  in  8  CAM confidence (uio_out).
- rsp_valid  out  1  response held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  2  requester index.
- rsp_op  out  1  echo of op.
- rsp_dist  out  5  distance.
- rsp_tag  out  2  address tag.
- rsp_conf  out  8  confidence.
- rsp_timeout  out  1  search timed out.
- busy  out  1  state != IDLE.
- stat_search  out  8  saturating count of completed searches.
- stat_timeout  out  8  saturating count of timed-out searches.

## Operation
- States:
  - IDLE → LOAD when any req_valid is set.
  - LOAD (4 cycles, nibble n = 0..3) → FIRE.
  - FIRE (search 1 cycle, write 2 cycles).
  - FIRE → WAIT for a search; FIRE → RESP for a write.
  - WAIT → RESP on cam_result[7], or when wait_cnt reaches TIMEOUT.
  - RESP → IDLE when rsp_ready is high.
- Arbitration is round-robin, evaluated only in IDLE.
  - Priority starts at (last_grant+1) mod NUM_REQ.
  - After reset, last_grant = NUM_REQ-1, so requester 0 wins first.
- Accept: in the IDLE cycle with a winner, req_ready[winner] = 1 for exactly that cycle.
  - The block latches op, pattern, cfg_mode and id in that cycle.
  - A requester must hold its inputs stable until req_ready.
- LOAD nibble n:
  - cam_ctrl = {0,0,0,mode,n}.
  - Search: cam_data = {4'h0, pat[4n+3:4n]}.
  - Write: cam_data = {pat[4n+3:4n], 4'h0}.
- FIRE: nibble index is held at 3 and cam_data keeps its nibble-3 value.
  - Search: cam_ctrl[7] = 1.
  - Write: cam_ctrl[6] = 1.
- In all other states, cam_ctrl = 0 and cam_data = 0.
- WAIT: wait_cnt starts at 0 and increments each WAIT cycle.
  - On the first cycle with cam_result[7] = 1, capture rsp_dist = cam_result[6:2], rsp_tag = cam_result[1:0], rsp_conf = cam_conf, rsp_timeout = 0.
  - If the result arrives on the same cycle wait_cnt reaches TIMEOUT, the result wins (no timeout).
  - On timeout: rsp_dist = 31, rsp_tag = 0, rsp_conf = 0, rsp_timeout = 1.
- Write response: rsp_dist = 0, rsp_tag = 0, rsp_conf = 0, rsp_timeout = 0.
- cam_result[7] seen outside WAIT is ignored.
- Statistics, updated on entry to RESP:
  - stat_search increments on each search completion, including timeouts.
  - stat_timeout increments on each timeout.
  - Both saturate at 255.
- Reset (synchronous, also mid-operation): the next edge forces IDLE and last_grant = NUM_REQ-1.
  - All outputs become 0, except rsp_dist = 31.
  - Any in-flight operation is dropped with no response.

## Timing
- Request accepted at cycle T (IDLE).
- LOAD occupies T+1..T+4. FIRE starts at T+5.
- Search: WAIT begins at T+6. rsp_valid is high the cycle after the capture cycle.
  - Worst case, rsp_valid is first high at T+6+TIMEOUT+1.
- Write: FIRE occupies T+5..T+6; rsp_valid is first high at T+7.
- All outputs are registered. rsp_* fields are stable while rsp_valid=1.
- The earliest next accept is the cycle after rsp_valid && rsp_ready (back in IDLE).
- req_valid dropping before req_ready cancels that request with no effect.

## Test plan
- Reset, then requester 0 search of 0x1234 at cycle T:
  - cam_data[3:0] = 4, 3, 2, 1 at T+1..T+4; cam_ctrl[7] = 1 only at T+5.
  - Model returns cam_result = 0x8E, cam_conf = 0x18 at T+8.
  - Expect rsp_valid at T+9 with rsp_dist = 3, rsp_tag = 2, rsp_conf = 0x18, rsp_id = 0, rsp_timeout = 0.
- Write of 0xBEEF from requester 1:
  - cam_data[7:4] = F, E, E, B over LOAD.
  - cam_ctrl[6] = 1 at T+5 and T+6.
  - rsp_valid at T+7 with rsp_op = 1, rsp_id = 1.
- Both requesters hold req_valid continuously with rsp_ready = 1: grants alternate 0, 1, 0, 1.
- Search with cam_result[7] never set and TIMEOUT = 15: rsp_timeout = 1, rsp_dist = 31, stat_timeout = 1, stat_search = 1.
- cam_result[7] pulses during LOAD, then never again: pulse ignored, timeout reported.
- rst_n low during WAIT for one cycle: next cycle busy = 0, rsp_valid = 0, cam_ctrl = 0; next grant goes to requester 0.
